// File: rtl/farm_sensor_pkg.sv
// Shared types and default limits for the farm-road detector conditioning path.
package farm_sensor_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUAL    = 3'd1,
    PRESENT = 3'd2,
    HOLD    = 3'd3,
    FAULT   = 3'd4
  } state_t;

  localparam int unsigned DEF_ON_SAMPLES    = 3;
  localparam int unsigned DEF_GAP_SAMPLES   = 4;
  localparam int unsigned DEF_STUCK_SAMPLES = 120;
  localparam int unsigned DEF_CNT_W         = 8;

endpackage

// File: rtl/farm_sensor_conditioner_sync.sv
// Generic two-flop synchroniser for asynchronous sensor inputs.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/farm_sensor_conditioner.sv
// Qualifies the farm-road loop detector into a debounced demand with gap-out hold,
// vehicle counting and stuck-detector fail-safe.
module farm_sensor_conditioner
  import farm_sensor_pkg::*;
#(
  parameter int unsigned ON_SAMPLES    = DEF_ON_SAMPLES,
  parameter int unsigned GAP_SAMPLES   = DEF_GAP_SAMPLES,
  parameter int unsigned STUCK_SAMPLES = DEF_STUCK_SAMPLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             det_raw,
  input  logic             cnt_clr,
  output logic             farm_sensor,
  output logic [CNT_W-1:0] vehicle_cnt,
  output logic             stuck_fault
);

  localparam int unsigned RUN_W = $clog2(ON_SAMPLES + 1);
  localparam int unsigned GAP_W = $clog2(GAP_SAMPLES + 1);
  localparam int unsigned ON_W  = $clog2(STUCK_SAMPLES + 1);

  // Compare against limit-1 so the counter only ever holds values up to its limit.
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(ON_SAMPLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_SAMPLES - 1);
  localparam logic [ON_W-1:0]  ON_LAST  = ON_W'(STUCK_SAMPLES - 1);

  logic             det_s;
  state_t           state;
  logic [RUN_W-1:0] run_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [ON_W-1:0]  on_cnt;
  logic             cnt_inc;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (det_raw),
    .q   (det_s)
  );

  always_comb begin
    cnt_inc = 1'b0;
    if (sample_en && det_s) begin
      if (state == IDLE && ON_SAMPLES == 1) cnt_inc = 1'b1;
      if (state == QUAL && run_cnt == RUN_LAST) cnt_inc = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      run_cnt     <= '0;
      gap_cnt     <= '0;
      on_cnt      <= '0;
      farm_sensor <= 1'b0;
      stuck_fault <= 1'b0;
    end else if (sample_en) begin
      case (state)
        IDLE: begin
          if (det_s) begin
            run_cnt <= RUN_W'(1);
            if (ON_SAMPLES == 1) begin
              state       <= PRESENT;
              on_cnt      <= '0;
              farm_sensor <= 1'b1;
            end else begin
              state <= QUAL;
            end
          end
        end
        QUAL: begin
          if (!det_s) begin
            state   <= IDLE;
            run_cnt <= '0;
          end else if (run_cnt == RUN_LAST) begin
            state       <= PRESENT;
            run_cnt     <= run_cnt + 1'b1;
            on_cnt      <= '0;
            farm_sensor <= 1'b1;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        PRESENT: begin
          if (det_s) begin
            on_cnt <= on_cnt + 1'b1;
            if (on_cnt == ON_LAST) begin
              state       <= FAULT;
              gap_cnt     <= '0;
              stuck_fault <= 1'b1;
            end
          end else if (GAP_SAMPLES == 1) begin
            state       <= IDLE;
            run_cnt     <= '0;
            farm_sensor <= 1'b0;
          end else begin
            state   <= HOLD;
            gap_cnt <= GAP_W'(1);
          end
        end
        HOLD: begin
          if (det_s) begin
            state  <= PRESENT;
            on_cnt <= '0;
          end else if (gap_cnt == GAP_LAST) begin
            state       <= IDLE;
            run_cnt     <= '0;
            gap_cnt     <= '0;
            farm_sensor <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        FAULT: begin
          if (det_s) begin
            gap_cnt <= '0;
          end else if (gap_cnt == GAP_LAST) begin
            state       <= IDLE;
            run_cnt     <= '0;
            gap_cnt     <= '0;
            on_cnt      <= '0;
            farm_sensor <= 1'b0;
            stuck_fault <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          farm_sensor <= 1'b0;
          stuck_fault <= 1'b0;
        end
      endcase
    end
  end

  // Clear is independent of sample_en and dominates a same-edge increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      vehicle_cnt <= '0;
    end else if (cnt_inc && vehicle_cnt != '1) begin
      vehicle_cnt <= vehicle_cnt + 1'b1;
    end
  end

endmodule
